// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control sequencer:
// opcodes, function fields, state codes, instruction classes and mux selects.
package ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRA  = 3'b101;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_ADD,
    OP_AND,
    OP_XOR,
    OP_SRA,
    OP_LW,
    OP_ADDI,
    OP_JALR,
    OP_SW,
    OP_JAL,
    OP_LUI
  } op_class_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_SRA = 2'b11;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_JAL   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMMU = 2'b11;

  function automatic logic [1:0] alu_op(input op_class_t c);
    logic [1:0] op;
    case (c)
      OP_AND:  op = ALU_AND;
      OP_XOR:  op = ALU_XOR;
      OP_SRA:  op = ALU_SRA;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Address and jump-target arithmetic all add the immediate to rs1.
  function automatic logic uses_imm(input op_class_t c);
    return (c == OP_ADDI) || (c == OP_LW) || (c == OP_SW) || (c == OP_JALR);
  endfunction

  function automatic logic is_mem_op(input op_class_t c);
    return (c == OP_LW) || (c == OP_SW);
  endfunction

  function automatic logic [1:0] pc_sel(input op_class_t c);
    logic [1:0] sel;
    case (c)
      OP_JAL:  sel = PC_JAL;
      OP_JALR: sel = PC_JALR;
      default: sel = PC_PLUS4;
    endcase
    return sel;
  endfunction

  function automatic logic [1:0] result_sel(input op_class_t c);
    logic [1:0] sel;
    case (c)
      OP_LW:           sel = RES_MEM;
      OP_JAL, OP_JALR: sel = RES_PC4;
      OP_LUI:          sel = RES_IMMU;
      default:         sel = RES_ALU;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Shared instruction/data memory port: request/write strobe out, completion ack back.
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_ack;

  modport master (output mem_req, output mem_we, input mem_ack);
  modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/mc_op_decode.sv
// Combinational instruction classifier: maps opcode/funct3/funct7 to an op class
// and flags anything outside the supported subset as illegal.
module mc_op_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output op_class_t   op_class,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_operand_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register and immediate fields belong to the datapath, not to classification.
  assign unused_operand_bits = ^{instr[24:15], instr[11:7]};

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    op_class = OP_NOP;
    case (opcode)
      OPC_RTYPE: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  op_class = OP_ADD;
            F3_AND:  op_class = OP_AND;
            F3_XOR:  op_class = OP_XOR;
            default: op_class = OP_NOP;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_SRA) begin
          op_class = OP_SRA;
        end
      end
      OPC_LOAD:  if (funct3 == F3_LW)   op_class = OP_LW;
      OPC_OPIMM: if (funct3 == F3_ADDI) op_class = OP_ADDI;
      OPC_JALR:  if (funct3 == F3_JALR) op_class = OP_JALR;
      OPC_STORE: if (funct3 == F3_SW)   op_class = OP_SW;
      OPC_JAL:   op_class = OP_JAL;
      OPC_LUI:   op_class = OP_LUI;
      default:   op_class = OP_NOP;
    endcase
  end

  assign legal = (op_class != OP_NOP);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a shared memory
// port, a req/ack watchdog, and a sticky trap on illegal opcodes or bus timeouts.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  instr,
  multicycle_ctrl_fsm_if.master        mem,
  output logic                         addr_sel,
  output logic                         ir_we,
  output logic                         pc_we,
  output logic [1:0]                   pc_src,
  output logic                         alu_src_b,
  output logic [1:0]                   alu_ctrl,
  output logic [1:0]                   result_src,
  output logic                         reg_we,
  output logic                         trap,
  output logic                         bus_err,
  output logic [2:0]                   state_dbg
);

  localparam logic [7:0] WD_LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [2:0] state, state_nx;
  op_class_t  op_class, op_class_nx;
  op_class_t  dec_class;
  logic       dec_legal;
  logic [7:0] wd_cnt, wd_cnt_nx;
  logic       trap_q, trap_nx;
  logic       bus_err_q, bus_err_nx;
  logic       ack;
  logic       wd_expired;
  logic       rd_zero;
  logic       req, we;

  mc_op_decode u_decode (
    .instr    (instr),
    .op_class (dec_class),
    .legal    (dec_legal)
  );

  assign ack        = mem.mem_ack;
  assign wd_expired = (wd_cnt == WD_LIMIT);
  assign rd_zero    = (instr[11:7] == 5'd0);

  // Next-state, class latch, watchdog and sticky fault logic.
  always_comb begin
    state_nx    = state;
    op_class_nx = op_class;
    wd_cnt_nx   = '0;
    trap_nx     = trap_q;
    bus_err_nx  = bus_err_q;
    case (state)
      S_FETCH: begin
        if (ack) begin
          state_nx = S_DECODE;
        end else if (wd_expired) begin
          state_nx   = S_TRAP;
          trap_nx    = 1'b1;
          bus_err_nx = 1'b1;
        end else begin
          wd_cnt_nx = wd_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        op_class_nx = dec_class;
        if (dec_legal) begin
          state_nx = S_EXEC;
        end else begin
          state_nx = S_TRAP;
          trap_nx  = 1'b1;
        end
      end
      S_EXEC: state_nx = is_mem_op(op_class) ? S_MEM : S_WB;
      S_MEM: begin
        if (ack) begin
          state_nx = (op_class == OP_SW) ? S_FETCH : S_WB;
        end else if (wd_expired) begin
          state_nx   = S_TRAP;
          trap_nx    = 1'b1;
          bus_err_nx = 1'b1;
        end else begin
          wd_cnt_nx = wd_cnt + 8'd1;
        end
      end
      S_WB:    state_nx = S_FETCH;
      S_TRAP:  state_nx = S_TRAP;
      default: begin
        state_nx = S_TRAP;
        trap_nx  = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      op_class  <= OP_NOP;
      wd_cnt    <= '0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      op_class  <= op_class_nx;
      wd_cnt    <= wd_cnt_nx;
      trap_q    <= trap_nx;
      bus_err_q <= bus_err_nx;
    end
  end

  // Datapath controls. The ALU selects stay valid from EXEC through WB so the
  // address (MEM) and JALR target (WB) see the same computation.
  always_comb begin
    req        = 1'b0;
    we         = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS4;
    alu_src_b  = 1'b0;
    alu_ctrl   = ALU_ADD;
    result_src = RES_ALU;
    reg_we     = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          req   = 1'b1;
          ir_we = ack;
        end
        S_EXEC: begin
          alu_ctrl  = alu_op(op_class);
          alu_src_b = uses_imm(op_class);
        end
        S_MEM: begin
          req       = 1'b1;
          addr_sel  = 1'b1;
          we        = (op_class == OP_SW);
          pc_we     = ack && (op_class == OP_SW);
          alu_ctrl  = alu_op(op_class);
          alu_src_b = uses_imm(op_class);
        end
        S_WB: begin
          pc_we      = 1'b1;
          pc_src     = pc_sel(op_class);
          result_src = result_sel(op_class);
          reg_we     = !rd_zero;
          alu_ctrl   = alu_op(op_class);
          alu_src_b  = uses_imm(op_class);
        end
        default: ;
      endcase
    end
  end

  // Holding reset drops every output at once, including a request in flight.
  assign mem.mem_req = req;
  assign mem.mem_we  = we;
  assign trap        = rst_n & trap_q;
  assign bus_err     = rst_n & bus_err_q;
  assign state_dbg   = rst_n ? state : S_FETCH;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: the driver queues the hand-derived
// expected output vector for each cycle, a monitor compares on the falling edge.
module tb_multicycle_ctrl_fsm;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       asel;
    logic       irwe;
    logic       pcwe;
    logic [1:0] pcsrc;
    logic       bsel;
    logic [1:0] aluc;
    logic [1:0] rsrc;
    logic       regwe;
    logic       trap;
    logic       berr;
  } obs_t;

  typedef struct packed {
    obs_t        v;
    obs_t        c;
    logic [15:0] id;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        addr_sel, ir_we, pc_we, alu_src_b, reg_we, trap, bus_err;
  logic [1:0]  pc_src, alu_ctrl, result_src;
  logic [2:0]  state_dbg;
  obs_t        got;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_push = 0;
  obs_t care_all;
  obs_t care_no_alu;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .mem        (bus.master),
    .addr_sel   (addr_sel),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .result_src (result_src),
    .reg_we     (reg_we),
    .trap       (trap),
    .bus_err    (bus_err),
    .state_dbg  (state_dbg)
  );

  assign got = {state_dbg, bus.mem_req, bus.mem_we, addr_sel, ir_we, pc_we, pc_src,
                alu_src_b, alu_ctrl, result_src, reg_we, trap, bus_err};

  always #5 clk = ~clk;

  // Monitor: one expected vector per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (((got ^ e.v) & e.c) !== '0) begin
          n_err++;
          $display("FAIL cycle%0d: got %h required %h (care %h)", e.id, got, e.v, e.c);
        end
      end
    end
  end

  function automatic obs_t mk(input logic [2:0] st);
    obs_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  task automatic step(input logic rn, input logic ack, input obs_t e, input obs_t c);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n       = rn;
    bus.mem_ack = ack;
    x.v  = e;
    x.c  = c;
    x.id = 16'(n_push);
    n_push++;
    exp_q.push_back(x);
  endtask

  task automatic reset_pulse();
    step(1'b0, 1'b1, mk(ST_FETCH), care_all);
  endtask

  task automatic fetch(input logic [31:0] ins, input int waits);
    obs_t e;
    e     = mk(ST_FETCH);
    e.req = 1'b1;
    for (int i = 0; i < waits; i++) begin
      step(1'b1, 1'b0, e, care_all);
      if (i == 0) instr = ins;
    end
    e.irwe = 1'b1;
    step(1'b1, 1'b1, e, care_all);
    if (waits == 0) instr = ins;
  endtask

  task automatic decode(input logic ack);
    step(1'b1, ack, mk(ST_DECODE), care_all);
  endtask

  task automatic exec(input logic [1:0] aluc, input logic bsel, input logic check_alu);
    obs_t e;
    e      = mk(ST_EXEC);
    e.aluc = aluc;
    e.bsel = bsel;
    step(1'b1, 1'b0, e, check_alu ? care_all : care_no_alu);
  endtask

  task automatic mem_phase(input logic we, input int waits, input logic store);
    obs_t e;
    e      = mk(ST_MEM);
    e.req  = 1'b1;
    e.asel = 1'b1;
    e.we   = we;
    for (int i = 0; i < waits; i++) step(1'b1, 1'b0, e, care_no_alu);
    e.pcwe = store;
    step(1'b1, 1'b1, e, care_no_alu);
  endtask

  task automatic wb(input logic regwe, input logic [1:0] pcsrc, input logic [1:0] rsrc);
    obs_t e;
    e       = mk(ST_WB);
    e.pcwe  = 1'b1;
    e.regwe = regwe;
    e.pcsrc = pcsrc;
    e.rsrc  = rsrc;
    step(1'b1, 1'b0, e, care_no_alu);
  endtask

  task automatic trap_cycles(input int n, input logic berr);
    obs_t e;
    e      = mk(ST_TRAP);
    e.trap = 1'b1;
    e.berr = berr;
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, e, care_all);
  endtask

  task automatic alu_instr(input logic [31:0] ins, input logic [1:0] aluc, input logic bsel);
    fetch(ins, 0);
    decode(1'b0);
    exec(aluc, bsel, 1'b1);
    wb(1'b1, 2'b00, 2'b00);
  endtask

  initial begin
    obs_t e;
    clk         = 1'b0;
    rst_n       = 1'b0;
    instr       = '0;
    bus.mem_ack = 1'b0;
    care_all    = '1;
    care_no_alu = '1;
    care_no_alu.aluc = 2'b00;
    care_no_alu.bsel = 1'b0;

    // Reset holds everything low even with a stray ack.
    reset_pulse();
    reset_pulse();

    // ADD x3,x1,x2 with ack one cycle after the request; ack in DECODE is ignored.
    fetch(32'h002081B3, 1);
    decode(1'b1);
    exec(2'b00, 1'b0, 1'b1);
    wb(1'b1, 2'b00, 2'b00);

    // LW x5,4(x1): data ack in the 4th MEM cycle, which is also the watchdog limit.
    fetch(32'h0040A283, 0);
    decode(1'b0);
    exec(2'b00, 1'b1, 1'b1);
    mem_phase(1'b0, 3, 1'b0);
    wb(1'b1, 2'b00, 2'b01);

    // SW x5,8(x1): PC update on the ack cycle, straight back to FETCH.
    fetch(32'h0050A423, 0);
    decode(1'b0);
    exec(2'b00, 1'b1, 1'b1);
    mem_phase(1'b1, 2, 1'b1);

    // JAL x1,+16 then JALR x0,0(x1).
    fetch(32'h010000EF, 0);
    decode(1'b0);
    exec(2'b00, 1'b0, 1'b0);
    wb(1'b1, 2'b01, 2'b10);
    fetch(32'h00008067, 0);
    decode(1'b0);
    exec(2'b00, 1'b1, 1'b1);
    wb(1'b0, 2'b10, 2'b10);

    // LUI x7,0x12345.
    fetch(32'h123453B7, 0);
    decode(1'b0);
    exec(2'b00, 1'b0, 1'b0);
    wb(1'b1, 2'b00, 2'b11);

    // Remaining ALU operations.
    alu_instr(32'h0020F233, 2'b01, 1'b0);  // AND x4,x1,x2
    alu_instr(32'h0020C233, 2'b10, 1'b0);  // XOR x4,x1,x2
    alu_instr(32'h4020D333, 2'b11, 1'b0);  // SRA x6,x1,x2
    alu_instr(32'h00500093, 2'b00, 1'b1);  // ADDI x1,x0,5

    // Illegal opcode, SRL (SRA with funct7=0) and SUB all trap without bus_err.
    fetch(32'h0000007F, 0);
    decode(1'b0);
    trap_cycles(3, 1'b0);
    reset_pulse();
    fetch(32'h0020D333, 0);
    decode(1'b0);
    trap_cycles(2, 1'b0);
    reset_pulse();
    fetch(32'h402081B3, 0);
    decode(1'b0);
    trap_cycles(2, 1'b0);
    reset_pulse();

    // Fetch watchdog: four unacknowledged FETCH cycles raise a bus error.
    e     = mk(ST_FETCH);
    e.req = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, e, care_all);
    trap_cycles(2, 1'b1);
    reset_pulse();

    // Ack in the limit cycle wins.
    alu_instr(32'h002081B3, 2'b00, 1'b0);
    fetch(32'h00500093, 3);
    decode(1'b0);
    exec(2'b00, 1'b1, 1'b1);
    wb(1'b1, 2'b00, 2'b00);

    // Data watchdog: SW never acknowledged in MEM.
    fetch(32'h0050A423, 0);
    decode(1'b0);
    exec(2'b00, 1'b1, 1'b1);
    e      = mk(ST_MEM);
    e.req  = 1'b1;
    e.asel = 1'b1;
    e.we   = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, e, care_no_alu);
    trap_cycles(1, 1'b1);
    reset_pulse();

    // Reset during a store in MEM: request and strobe drop that cycle, then FETCH
    // with a fresh watchdog (ack in the 4th cycle still succeeds).
    fetch(32'h0050A423, 0);
    decode(1'b0);
    exec(2'b00, 1'b1, 1'b1);
    step(1'b1, 1'b0, e, care_no_alu);
    step(1'b0, 1'b0, mk(ST_FETCH), care_all);
    fetch(32'h0020C233, 3);
    decode(1'b0);
    exec(2'b10, 1'b0, 1'b1);
    wb(1'b1, 2'b00, 2'b00);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d checks pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
